p2s_ser_ctrl: RTL
=================

# p2s_ser_ctrl

Parametrised, register-controlled parallel-to-serial converter with a transmit FIFO, bit-period divider and selectable bit order. The host drives the command bus (cmd/rnw/addr/data_in) to queue words and control the block. The block serialises each queued word onto a single output with a framing strobe. It is the next-generation P2S DUT behind the existing command-style agent.

## Interface
- DATA_W, 8, word width in bits (≥8).
- ADDR_W, 8, command address width (≥2).
- DEPTH, 4, TX FIFO depth in words (power of 2, ≥2).
- BIT_DIV, 1, clock cycles per serial bit (≥1).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd  in  1  command strobe; one command per cycle when high.
- rnw  in  1  1 = read, 0 = write; qualified by cmd.
- addr  in  ADDR_W  register address.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data; reset 0.
- rd_valid  out  1  one-cycle pulse when data_out holds read data; reset 0.
- busy  out  1  registered; high while FIFO full; reset 0.
- ser_out  out  1  serial data bit; reset 0; 0 whenever ser_en is low.
- ser_en  out  1  high while a word (and parity, if compiled) is on ser_out; reset 0.

## Operation
- Register map, with unlisted addresses ignored on write and read as 0:
  - 0x00 TXDATA (W): pushes data_in into the FIFO. If the FIFO is full, the word is dropped and STATUS.ovf is set.
  - 0x01 CTRL (R/W): bit0 enable, bit1 lsb_first; other bits read 0; reset 0.
  - 0x02 STATUS (R): bit0 empty, bit1 full, bit2 ovf (sticky, cleared by the read that returns it), bit3 shifting; other bits read 0.
  - TXDATA reads return 0.
- FIFO full/empty is evaluated at the current cycle. A push into a full FIFO is dropped even if a pop occurs in the same cycle. A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Serializer FSM states:
  - IDLE → SHIFT when enable=1 and FIFO not empty. The FIFO is popped and the shift register loaded on that edge.
  - SHIFT: each bit is held for BIT_DIV cycles. MSB is sent first unless lsb_first; lsb_first is sampled at load.
  - After DATA_W bits the FSM goes to PAR (if compiled) for one bit period, otherwise to IDLE.
  - PAR → IDLE.
  - ser_en is low for at least one cycle in IDLE between words.
- Clearing enable mid-word does not abort: the current word completes, and no new pop occurs.
- Reset mid-word aborts the word. FIFO contents, CTRL and ovf are cleared. All outputs return to their reset values after the reset edge.

## Timing
- Read: cmd&rnw sampled at edge k; data_out and rd_valid are valid after edge k, for one cycle.
- Write: takes effect at the sampling edge. Count and busy update after edge k.
- First bit latency: when enabled, idle and the FIFO is empty, a TXDATA write at edge k puts the first bit on ser_out, with ser_en=1, after edge k+1.
- Word duration: DATA_W×BIT_DIV cycles, plus BIT_DIV for parity. Back-to-back words are separated by exactly one ser_en-low cycle.
- The bit-period counter wraps at BIT_DIV-1. It resets to 0 at each load.

## Configuration
- P2S_PARITY_EN defined: after the last data bit, one extra bit period carries even parity (XOR of all DATA_W bits), and ser_en stays high through it.
- P2S_PARITY_EN undefined: there is no PAR state and frames contain data bits only.

## Structure
- Package p2s_pkg holds:
  - register address constants (TXDATA/CTRL/STATUS);
  - CTRL and STATUS bit-index constants;
  - the FSM state enum (IDLE, SHIFT, PAR).
- Sub-module p2s_fifo: synchronous FIFO parametrised by DATA_W and DEPTH, with push, pop, full, empty, and a count of $clog2(DEPTH)+1 bits.

## Test plan
- Reset values: assert rst for 2 cycles → all outputs 0; STATUS reads 0x01 (empty).
- Basic MSB-first frame, DATA_W=8, BIT_DIV=1: write CTRL=0x1, then TXDATA=0xA5 → ser_out sequence 1,0,1,0,0,1,0,1 with ser_en high for 8 cycles, starting 2 edges after the write.
- LSB-first with BIT_DIV=3: CTRL=0x3, TXDATA=0x01 → ser_out is 1 for 3 cycles, then 0 for 21 cycles; ser_en is high for 24 cycles.
- Overflow: with enable=0, write DEPTH+1 words → busy=1 after the DEPTH-th write; STATUS reads 0x06 (full|ovf); a second STATUS read returns 0x02.
- Disable mid-word: with 2 words queued, clear enable during the first word → the first word completes, the second is not sent, and STATUS.empty=0.
- Parity (macro on): TXDATA=0x07 → 8 data bits then ser_out=1, with ser_en high for 9 bit periods. Reset mid-word → ser_en=0 after the reset edge and the FIFO is empty.

Source files
------------

// File: rtl/p2s_pkg.sv
// ---------------------------------------------------------------------------
// p2s_pkg
// Shared definitions for the parallel-to-serial controller:
//   - command register addresses (TXDATA / CTRL / STATUS)
//   - bit positions inside the CTRL and STATUS registers
//   - serializer state enumeration
// Configuration macro honoured by the design: P2S_PARITY_EN
// ---------------------------------------------------------------------------
package p2s_pkg;

    // Register addresses on the command bus
    localparam int ADDR_TXDATA = 0;
    localparam int ADDR_CTRL   = 1;
    localparam int ADDR_STATUS = 2;

    // CTRL register fields
    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_LSB_FIRST_BIT = 1;

    // STATUS register fields
    localparam int STAT_EMPTY_BIT    = 0;
    localparam int STAT_FULL_BIT     = 1;
    localparam int STAT_OVF_BIT      = 2;
    localparam int STAT_SHIFTING_BIT = 3;

    // Serializer states; PAR is only reachable when parity is compiled in
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } serState_t;

endpackage

// File: rtl/p2s_fifo.sv
// ---------------------------------------------------------------------------
// p2s_fifo
// Synchronous single-clock FIFO holding words waiting to be serialised.
// Full/empty are decoded from the registered occupancy count, so a push
// into a full FIFO is dropped even when a pop happens in the same cycle.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_push         write i_wrData (ignored when full)
//   i_pop          discard head word (ignored when empty)
//   i_wrData       word to store
//   o_rdData       current head word (valid when not empty)
//   o_full/o_empty occupancy flags
//   o_count        number of stored words, $clog2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module p2s_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [DATA_W-1:0]         i_wrData,
    output logic [DATA_W-1:0]         o_rdData,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              w_doPush;
    logic              w_doPop;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_rdData = r_mem[r_rdPtr];

    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;

    // Storage array; contents need no reset because the count guards them
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/p2s_ser_ctrl.sv
// ---------------------------------------------------------------------------
// p2s_ser_ctrl
// Register-controlled parallel-to-serial converter. Words written to TXDATA
// are queued in a FIFO and shifted out on ser_out, one bit every BIT_DIV
// clocks, with ser_en framing each word.
// Optional feature macro: P2S_PARITY_EN -- appends one even-parity bit
// period to every frame.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd, rnw            command strobe and read(1)/write(0) select
//   addr, data_in       register address and write data
//   data_out, rd_valid  registered read data and its one-cycle strobe
//   busy                registered FIFO-full indication
//   ser_out, ser_en     serial bit and frame strobe
// ---------------------------------------------------------------------------
module p2s_ser_ctrl
    import p2s_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 4,
    parameter int BIT_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd,
    input  logic              rnw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              ser_out,
    output logic              ser_en
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    // Command decode
    logic w_isWrite;
    logic w_isRead;
    logic w_txWrite;
    logic w_ctrlWrite;
    logic w_statusRead;

    // FIFO interface
    logic [DATA_W-1:0] w_fifoHead;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_countNext;
    logic              w_pushOk;
    logic              w_pop;

    // Control / status registers
    logic r_enable;
    logic r_lsbCfg;
    logic r_ovf;
    logic r_busy;

    // Read path
    logic [DATA_W-1:0] w_rdData;
    logic [DATA_W-1:0] r_dataOut;
    logic              r_rdValid;

    // Serializer
    serState_t         r_state;
    serState_t         w_stateNext;
    logic [DATA_W-1:0] r_shift;
    logic              r_txLsbFirst;
    logic [BIT_W-1:0]  r_bitCnt;
    logic [DIV_W-1:0]  r_divCnt;
    logic              w_bitEnd;
    logic              w_lastBit;
`ifdef P2S_PARITY_EN
    logic              r_parity;
`endif

    assign w_isWrite    = cmd & ~rnw;
    assign w_isRead     = cmd & rnw;
    assign w_txWrite    = w_isWrite & (addr == ADDR_W'(ADDR_TXDATA));
    assign w_ctrlWrite  = w_isWrite & (addr == ADDR_W'(ADDR_CTRL));
    assign w_statusRead = w_isRead & (addr == ADDR_W'(ADDR_STATUS));
    assign w_pushOk     = w_txWrite & ~w_full;

    assign w_bitEnd  = (r_divCnt == DIV_W'(BIT_DIV - 1));
    assign w_lastBit = (r_bitCnt == BIT_W'(DATA_W - 1));

    assign data_out = r_dataOut;
    assign rd_valid = r_rdValid;
    assign busy     = r_busy;

    p2s_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_push   (w_txWrite),
        .i_pop    (w_pop),
        .i_wrData (data_in),
        .o_rdData (w_fifoHead),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_count)
    );

    // Occupancy after this edge, so busy can be a plain register that
    // tracks full without lagging a cycle behind the FIFO
    always_comb begin
        w_countNext = w_count;
        if (w_pushOk && !w_pop) begin
            w_countNext = w_count + CNT_W'(1);
        end else if (!w_pushOk && w_pop) begin
            w_countNext = w_count - CNT_W'(1);
        end
    end

    // CTRL register, overflow flag and busy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable <= 1'b0;
            r_lsbCfg <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (w_ctrlWrite) begin
                r_enable <= data_in[CTRL_ENABLE_BIT];
                r_lsbCfg <= data_in[CTRL_LSB_FIRST_BIT];
            end
            // Only one command per cycle, so a dropped push and a STATUS
            // read can never collide
            if (w_txWrite && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_statusRead) begin
                r_ovf <= 1'b0;
            end
            r_busy <= (w_countNext == CNT_W'(DEPTH));
        end
    end

    // Register read multiplexer; unmapped and write-only addresses read 0
    always_comb begin
        w_rdData = '0;
        if (addr == ADDR_W'(ADDR_CTRL)) begin
            w_rdData[CTRL_ENABLE_BIT]    = r_enable;
            w_rdData[CTRL_LSB_FIRST_BIT] = r_lsbCfg;
        end else if (addr == ADDR_W'(ADDR_STATUS)) begin
            w_rdData[STAT_EMPTY_BIT]    = w_empty;
            w_rdData[STAT_FULL_BIT]     = w_full;
            w_rdData[STAT_OVF_BIT]      = r_ovf;
            w_rdData[STAT_SHIFTING_BIT] = (r_state != IDLE);
        end
    end

    // Read response is registered and pulses for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dataOut <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= w_isRead;
            if (w_isRead) begin
                r_dataOut <= w_rdData;
            end
        end
    end

    // Serializer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Serializer next-state logic; enable is only consulted in IDLE, so
    // clearing it mid-word lets the current frame finish
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (r_enable && !w_empty) begin
                    w_stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (w_bitEnd && w_lastBit) begin
`ifdef P2S_PARITY_EN
                    w_stateNext = PAR;
`else
                    w_stateNext = IDLE;
`endif
                end
            end
`ifdef P2S_PARITY_EN
            PAR: begin
                if (w_bitEnd) begin
                    w_stateNext = IDLE;
                end
            end
`endif
            default: w_stateNext = IDLE;
        endcase
    end

    // Serializer outputs; the pop happens on the same edge that loads
    // the shift register
    always_comb begin
        ser_en  = 1'b0;
        ser_out = 1'b0;
        w_pop   = 1'b0;
        case (r_state)
            IDLE: begin
                w_pop = r_enable & ~w_empty;
            end
            SHIFT: begin
                ser_en  = 1'b1;
                ser_out = r_txLsbFirst ? r_shift[0] : r_shift[DATA_W-1];
            end
`ifdef P2S_PARITY_EN
            PAR: begin
                ser_en  = 1'b1;
                ser_out = r_parity;
            end
`endif
            default: begin
                ser_en  = 1'b0;
                ser_out = 1'b0;
            end
        endcase
    end

    // Shift register and bit/period counters. The outgoing bit always sits
    // at one end of r_shift, so shifting toward it exposes the next bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_txLsbFirst <= 1'b0;
            r_bitCnt     <= '0;
            r_divCnt     <= '0;
`ifdef P2S_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else if (w_pop) begin
            r_shift      <= w_fifoHead;
            r_txLsbFirst <= r_lsbCfg;
            r_bitCnt     <= '0;
            r_divCnt     <= '0;
`ifdef P2S_PARITY_EN
            r_parity     <= ^w_fifoHead;
`endif
        end else if (r_state != IDLE) begin
            if (w_bitEnd) begin
                r_divCnt <= '0;
                if (r_state == SHIFT) begin
                    r_bitCnt <= r_bitCnt + BIT_W'(1);
                    if (r_txLsbFirst) begin
                        r_shift <= {1'b0, r_shift[DATA_W-1:1]};
                    end else begin
                        r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                    end
                end
            end else begin
                r_divCnt <= r_divCnt + DIV_W'(1);
            end
        end
    end

endmodule
